// File: rtl/driver_complex_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : driver_complex_multiplier
// Purpose  : Operand initiator and result sink agent for the complex multiplier.
// Revision : 1.0
// ============================================================================
module driver_complex_multiplier #(
    parameter int         DATA_WIDTH      = 8,
    parameter int         NR_TRANS        = 16,
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [3:0] READY_PATTERN   = 4'b1011,
    parameter int         TIMEOUT         = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sw_rst,
    input  logic                    start,
    output logic                    op_val,
    input  logic                    op_ready,
    output logic [4*DATA_WIDTH-1:0] op_data,
    input  logic                    res_val,
    output logic                    res_ready,
    input  logic [4*DATA_WIDTH-1:0] res_data,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              sent_cnt,
    output logic [7:0]              recv_cnt,
    output logic                    err_unexp,
    output logic                    err_timeout
);

    localparam int         c_TW  = $clog2(TIMEOUT + 1);
    localparam logic [7:0] c_NR  = 8'(NR_TRANS);
    localparam logic [3:0] c_MAX = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_op_val;
    logic [4*DATA_WIDTH-1:0] r_op_data;
    logic                    r_res_ready;
    logic [3:0]              r_pat;
    logic [7:0]              r_sent;
    logic [7:0]              r_recv;
    logic [3:0]              r_outst;
    logic [c_TW-1:0]         r_timer;
    logic                    r_err_unexp;
    logic                    r_err_to;

    logic       w_busy;
    logic       w_op_hs;
    logic       w_res_hs;
    logic       w_unexp;
    logic       w_res_cnt;
    logic [7:0] w_sent_nxt;
    logic [7:0] w_recv_nxt;
    logic [3:0] w_outst_nxt;
    logic       w_tmr_inc;
    logic       w_timeout;

    // Operand i is {i, i+1, i+2, i+3}, each field wrapping at DATA_WIDTH.
    function automatic logic [4*DATA_WIDTH-1:0] f_opd(input logic [7:0] i);
        logic [DATA_WIDTH-1:0] b;
        b = DATA_WIDTH'(i);
        return {b, b + DATA_WIDTH'(1), b + DATA_WIDTH'(2), b + DATA_WIDTH'(3)};
    endfunction

    assign w_busy     = (r_state == S_SEND) || (r_state == S_DRAIN);
    assign w_op_hs    = r_op_val & op_ready;
    assign w_res_hs   = res_val & r_res_ready;
    assign w_unexp    = w_res_hs && (r_outst == 4'd0);
    assign w_res_cnt  = w_res_hs && !w_unexp;
    assign w_sent_nxt = (w_op_hs && r_sent != 8'hFF) ? r_sent + 8'd1 : r_sent;
    assign w_recv_nxt = (w_res_cnt && r_recv != 8'hFF) ? r_recv + 8'd1 : r_recv;
    assign w_outst_nxt = (w_op_hs && !w_res_cnt) ? r_outst + 4'd1 :
                         (!w_op_hs && w_res_cnt) ? r_outst - 4'd1 : r_outst;
    assign w_tmr_inc  = w_busy && !w_res_hs && (r_outst != 4'd0);
    assign w_timeout  = w_tmr_inc && (r_timer == c_TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_op_val    <= 1'b0;
            r_op_data   <= '0;
            r_res_ready <= 1'b0;
            r_pat       <= READY_PATTERN;
            r_sent      <= 8'd0;
            r_recv      <= 8'd0;
            r_outst     <= 4'd0;
            r_timer     <= '0;
            r_err_unexp <= 1'b0;
            r_err_to    <= 1'b0;
        end else if (sw_rst) begin
            r_state     <= S_IDLE;
            r_op_val    <= 1'b0;
            r_op_data   <= '0;
            r_res_ready <= 1'b0;
            r_pat       <= READY_PATTERN;
            r_sent      <= 8'd0;
            r_recv      <= 8'd0;
            r_outst     <= 4'd0;
            r_timer     <= '0;
            r_err_unexp <= 1'b0;
            r_err_to    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // Fresh run: bit 0 of the pattern drives the first SEND cycle.
                        r_state     <= S_SEND;
                        r_op_val    <= 1'b1;
                        r_op_data   <= f_opd(8'd0);
                        r_res_ready <= READY_PATTERN[0];
                        r_pat       <= {READY_PATTERN[0], READY_PATTERN[3:1]};
                        r_sent      <= 8'd0;
                        r_recv      <= 8'd0;
                        r_outst     <= 4'd0;
                        r_timer     <= '0;
                        r_err_unexp <= 1'b0;
                        r_err_to    <= 1'b0;
                    end
                end
                default: begin
                    r_sent      <= w_sent_nxt;
                    r_recv      <= w_recv_nxt;
                    r_outst     <= w_outst_nxt;
                    r_timer     <= w_tmr_inc ? r_timer + c_TW'(1) : '0;
                    r_pat       <= {r_pat[0], r_pat[3:1]};
                    r_res_ready <= r_pat[0];
                    if (w_unexp) begin
                        r_err_unexp <= 1'b1;
                    end
                    if (w_op_hs) begin
                        r_op_data <= f_opd(w_sent_nxt);
                    end
                    if (w_timeout) begin
                        r_err_to    <= 1'b1;
                        r_state     <= S_DONE;
                        r_op_val    <= 1'b0;
                        r_res_ready <= 1'b0;
                    end else if (r_state == S_SEND && w_op_hs && w_sent_nxt == c_NR) begin
                        r_state  <= S_DRAIN;
                        r_op_val <= 1'b0;
                    end else if (r_state == S_DRAIN && w_recv_nxt == c_NR) begin
                        r_state     <= S_DONE;
                        r_res_ready <= 1'b0;
                    end else begin
                        // A pending operand is never withdrawn, only new ones are gated.
                        r_op_val <= (r_state == S_SEND) &&
                                    ((r_op_val && !op_ready) ||
                                     (w_sent_nxt < c_NR && w_outst_nxt < c_MAX));
                    end
                end
            endcase
        end
    end

    assign op_val      = r_op_val;
    assign op_data     = r_op_data;
    assign res_ready   = r_res_ready;
    assign busy        = w_busy;
    assign done        = (r_state == S_DONE);
    assign sent_cnt    = r_sent;
    assign recv_cnt    = r_recv;
    assign err_unexp   = r_err_unexp;
    assign err_timeout = r_err_to;

    logic w_unused;
    assign w_unused = ^res_data;

endmodule
`default_nettype wire

// File: tb/tb_driver_complex_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_driver_complex_multiplier
// Purpose  : Randomized bench comparing the driver against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_driver_complex_multiplier;

    localparam int         c_DW  = 8;
    localparam int         c_NR  = 10;
    localparam int         c_MAX = 4;
    localparam logic [3:0] c_PAT = 4'b1011;
    localparam int         c_TO  = 64;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              sw_rst = 1'b0;
    logic              start = 1'b0;
    logic              op_val;
    logic              op_ready = 1'b0;
    logic [4*c_DW-1:0] op_data;
    logic              res_val = 1'b0;
    logic              res_ready;
    logic [4*c_DW-1:0] res_data = '0;
    logic              busy;
    logic              done;
    logic [7:0]        sent_cnt;
    logic [7:0]        recv_cnt;
    logic              err_unexp;
    logic              err_timeout;

    driver_complex_multiplier #(
        .DATA_WIDTH     (c_DW),
        .NR_TRANS       (c_NR),
        .MAX_OUTSTANDING(c_MAX),
        .READY_PATTERN  (c_PAT),
        .TIMEOUT        (c_TO)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .sw_rst     (sw_rst),
        .start      (start),
        .op_val     (op_val),
        .op_ready   (op_ready),
        .op_data    (op_data),
        .res_val    (res_val),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done),
        .sent_cnt   (sent_cnt),
        .recv_cnt   (recv_cnt),
        .err_unexp  (err_unexp),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int q[$];

    // Transaction-level model: 0 idle, 1 send, 2 drain, 3 done.
    int m_st, m_sent, m_recv, m_phase, m_idle;
    bit m_eu, m_et, m_opv, m_rr;
    logic [3:0] pat_v = c_PAT;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_data(input int i);
        return {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
    endfunction

    task automatic model_reset();
        m_st = 0; m_sent = 0; m_recv = 0; m_phase = 0; m_idle = 0;
        m_eu = 0; m_et = 0; m_opv = 0; m_rr = 0;
        q.delete();
    endtask

    task automatic check_all();
        chk("busy", busy, (m_st == 1 || m_st == 2));
        chk("done", done, (m_st == 3));
        chk("op_val", op_val, m_opv);
        chk("res_ready", res_ready, m_rr);
        chk("sent_cnt", sent_cnt, m_sent);
        chk("recv_cnt", recv_cnt, m_recv);
        chk("err_unexp", err_unexp, m_eu);
        chk("err_timeout", err_timeout, m_et);
        if (m_opv) chk("op_data", op_data, exp_data(m_sent));
    endtask

    // opr: 0 low, 1 high, 2 random. resp: return queued results. spur: force res_val.
    task automatic run_cycle(input bit st, input int opr, input bit resp, input bit spur);
        bit hs_op, hs_res, prev_opv;
        int outst;
        @(negedge clk);
        start    = st;
        op_ready = (opr == 2) ? ($urandom_range(0, 9) < 7) : (opr == 1);
        res_val  = spur || (resp && q.size() > 0 && q[0] <= cyc);
        res_data = $urandom;
        hs_op    = m_opv && op_ready;
        hs_res   = res_val && m_rr;
        prev_opv = m_opv;
        @(posedge clk);
        #1;
        cyc++;
        if (st && (m_st == 0 || m_st == 3)) begin
            m_st = 1; m_sent = 0; m_recv = 0; m_eu = 0; m_et = 0;
            m_idle = 0; m_phase = 0; prev_opv = 0; q.delete();
        end else if (m_st == 1 || m_st == 2) begin
            outst = m_sent - m_recv;
            if (hs_res) begin
                if (outst == 0) m_eu = 1;
                else begin
                    m_recv++;
                    if (q.size() > 0) void'(q.pop_front());
                end
            end
            if (hs_op) begin
                m_sent++;
                q.push_back(cyc + $urandom_range(1, 6));
            end
            if (hs_res || outst == 0) m_idle = 0;
            else m_idle++;
            m_phase++;
            if (m_idle == c_TO) begin
                m_et = 1; m_st = 3;
            end else if (m_st == 1 && m_sent == c_NR) m_st = 2;
            else if (m_st == 2 && m_recv == c_NR) m_st = 3;
        end
        m_opv = (m_st == 1) && ((prev_opv && !hs_op) ||
                (m_sent < c_NR && (m_sent - m_recv) < c_MAX));
        m_rr  = (m_st == 1 || m_st == 2) ? pat_v[m_phase % 4] : 1'b0;
        check_all();
    endtask

    task automatic run_until_done(input int maxc, input int opr, input bit resp);
        for (int k = 0; k < maxc && m_st != 3; k++) run_cycle(0, opr, resp, 0);
        chk("done_within_budget", done, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 0; start = 0; op_ready = 0; res_val = 0;
        #1;
        model_reset();
        check_all();
        chk("reset_op_data", op_data, 0);
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic do_swrst();
        @(negedge clk);
        sw_rst = 1; start = 0; op_ready = 0; res_val = 0;
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        chk("swrst_op_data", op_data, 0);
        @(negedge clk);
        sw_rst = 0;
    endtask

    logic [7:0] rr_seq;

    initial begin
        model_reset();
        do_reset();

        // Random traffic run, with pinned first operand and ready pattern.
        run_cycle(1, 2, 1, 0);
        chk("first_op_data", op_data, 32'h00010203);
        rr_seq[0] = res_ready;
        for (int k = 1; k < 8; k++) begin
            run_cycle(0, 2, 1, 0);
            rr_seq[k] = res_ready;
        end
        chk("ready_pattern_seq", rr_seq, 8'hBB);
        run_until_done(400, 2, 1);
        chk("run1_sent", sent_cnt, 10);
        chk("run1_recv", recv_cnt, 10);
        chk("run1_errs", {err_unexp, err_timeout}, 0);

        // Stall operand 2 for five cycles.
        run_cycle(1, 1, 1, 0);
        for (int k = 0; k < 50 && m_sent < 2; k++) run_cycle(0, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            run_cycle(0, 0, 1, 0);
            chk("stall_op_val", op_val, 1);
            chk("stall_op_data", op_data, 32'h02030405);
            chk("stall_sent", sent_cnt, 2);
        end
        run_cycle(0, 1, 1, 0);
        chk("stall_release_sent", sent_cnt, 3);
        run_until_done(400, 2, 1);

        // Result with nothing outstanding.
        run_cycle(1, 0, 0, 0);
        run_cycle(0, 0, 0, 1);
        chk("unexp_flag", err_unexp, 1);
        chk("unexp_recv", recv_cnt, 0);
        run_until_done(400, 2, 1);
        chk("unexp_sticky", err_unexp, 1);

        // DUT never answers: limit then timeout.
        run_cycle(1, 1, 0, 0);
        for (int k = 0; k < 200 && m_st != 3; k++) run_cycle(0, 1, 0, 0);
        chk("to_sent", sent_cnt, 4);
        chk("to_flag", err_timeout, 1);
        chk("to_done", done, 1);
        chk("to_op_val", op_val, 0);

        // Asynchronous reset in DRAIN, then a fresh run.
        run_cycle(1, 1, 1, 0);
        for (int k = 0; k < 100 && m_st != 2; k++) run_cycle(0, 1, 1, 0);
        chk("reached_drain", m_st == 2 && busy, 1);
        do_reset();
        run_cycle(1, 2, 1, 0);
        chk("restart_op_data", op_data, 32'h00010203);
        chk("restart_op_val", op_val, 1);
        for (int k = 0; k < 6; k++) run_cycle(0, 2, 1, 0);

        // Synchronous clear mid-SEND, then a complete run.
        do_swrst();
        run_cycle(1, 2, 1, 0);
        run_until_done(400, 2, 1);
        chk("final_recv", recv_cnt, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/driver_complex_multiplier.md
Name: driver_complex_multiplier

Overview:
- Active stimulus and sink agent for the complex multiplier's operand and result valid/ready interfaces.
- Acts as the initiator that a passive monitor only observes: it drives op_val/op_data, accepts results through res_ready with a programmable backpressure pattern, and tracks outstanding transactions.
- Instantiated in the multiplier bench alongside the DUT and monitor; written in synthesizable style.

Parameters:
- DATA_WIDTH, 8, width of each operand field (a_re, a_im, b_re, b_im).
- NR_TRANS, 16, operand transactions issued per run (1..255).
- MAX_OUTSTANDING, 4, maximum accepted operands without a received result (1..15).
- READY_PATTERN, 4'b1011, res_ready pattern; bit 0 is used first, then the pattern rotates right by one each cycle.
- TIMEOUT, 64, idle cycles tolerated while results are outstanding.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- sw_rst  input  1  synchronous clear; same effect as reset
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE
- op_val  output  1  operand valid
- op_ready  input  1  DUT accepts operand
- op_data  output  4*DATA_WIDTH  {a_re, a_im, b_re, b_im}, MSB first
- res_val  input  1  result valid
- res_ready  output  1  driver accepts result
- res_data  input  4*DATA_WIDTH  {re, im}; not checked here
- busy  output  1  high in SEND or DRAIN
- done  output  1  high in DONE
- sent_cnt  output  8  operands accepted (op_val & op_ready)
- recv_cnt  output  8  results accepted (res_val & res_ready)
- err_unexp  output  1  sticky; result received with outstanding==0
- err_timeout  output  1  sticky; TIMEOUT expired

Behaviour:
- Reset (rstn low, async) or sw_rst (sync): state IDLE; op_val=0, op_data=0, res_ready=0, busy=0, done=0, counts=0, errors=0, pattern register=READY_PATTERN, idle timer=0.
- Operand i (0-based sent_cnt): a_re=i, a_im=i+1, b_re=i+2, b_im=i+3, each taken mod 2^DATA_WIDTH.
- outstanding = sent_cnt - recv_cnt, kept as an internal 4-bit counter. It increments on op handshake and decrements on res handshake; both in the same cycle leaves it unchanged.
- States:
  - IDLE: outputs quiet. start -> SEND; on that edge, counts, errors and pattern are cleared/reloaded.
  - SEND: op_val=1 when sent_cnt<NR_TRANS and outstanding<MAX_OUTSTANDING, registered for the next cycle. An accepted operand updates op_data to i+1 on the same edge. When the NR_TRANS-th handshake occurs -> DRAIN.
  - DRAIN: op_val=0. When recv_cnt==NR_TRANS -> DONE.
  - DONE: done=1, res_ready=0. start -> SEND with a fresh run. start while in SEND or DRAIN is ignored.
- Valid/ready rules:
  - Once op_val is asserted, op_val and op_data hold stable until op_ready is sampled high.
  - op_val never drops without a handshake, even if outstanding would exceed the limit.
  - Handshake when op_val & op_ready are both high at a rising edge.
- res_ready: in SEND and DRAIN, res_ready = pattern[0] (registered); the pattern rotates right every cycle regardless of res_val. res_ready=0 in IDLE and DONE.
- Result accept: res_val & res_ready increments recv_cnt. If outstanding==0 at that edge, set err_unexp, do not increment recv_cnt, keep outstanding at 0.
- Timeout:
  - The idle timer increments each cycle in SEND or DRAIN while outstanding>0 and no result handshake occurs; it clears on a result handshake or when outstanding==0.
  - Timer reaching TIMEOUT -> err_timeout=1, state DONE, op_val=0.
- Counters saturate at 255.
- Latency: op_val asserts on the cycle after start. First op_data = {0,1,2,3}.
- Reset mid-run: all state cleared immediately; no transaction in flight is retained.

Test Plan:
- Ideal DUT (op_ready=1, results 3 cycles after each op, READY_PATTERN=4'b1111, NR_TRANS=4) -> ops {0,1,2,3},{1,2,3,4},{2,3,4,5},{3,4,5,6}; sent_cnt=recv_cnt=4; done=1; no errors.
- op_ready low for 5 cycles on op 2 -> op_val and op_data={2,3,4,5} stable all 5 cycles; single handshake; sent_cnt increments once.
- DUT never returns results, MAX_OUTSTANDING=4 -> op_val low after 4 handshakes; err_timeout=1 after 64 idle cycles; state DONE with sent_cnt=4.
- res_val pulsed with no outstanding ops -> err_unexp=1; recv_cnt stays 0.
- READY_PATTERN=4'b1011 with res_val held high -> res_ready sequence 1,1,0,1 repeating; recv_cnt matches the count of high cycles.
- rstn asserted mid-DRAIN, then start -> all outputs at reset values; new run begins with op_data={0,1,2,3}.
